// File: rtl/nand_gate_core.sv
// nand_gate_core: parameterisable bitwise NAND primitive.
// Provides a combinational result and a registered result behind an optional
// per-operand synchroniser. A saturating counter records how many clock cycles
// changed the registered result.
module nand_gate_core #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_0,
    input  logic [WIDTH-1:0] i_1,
    input  logic             i_en,
    input  logic             i_clr_cnt,
    output logic [WIDTH-1:0] o_0,
    output logic [WIDTH-1:0] o_0_comb,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_toggle_cnt
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic [WIDTH-1:0] o0_d,    o0_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;

    // Combinational NAND straight from the ports. It does not depend on the
    // clock, the reset or i_en.
    assign o_0_comb = ~(i_0 & i_1);

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            // Each operand uses a flat shift register. Stage k occupies bits
            // [(k+1)*WIDTH-1 : k*WIDTH]. Stage 0 takes the raw input, and the
            // highest stage drives the NAND.
            logic [SYNC_STAGES*WIDTH-1:0] sync_a_d, sync_a_q;
            logic [SYNC_STAGES*WIDTH-1:0] sync_b_d, sync_b_q;

            if (SYNC_STAGES == 1) begin : g_one
                // Next-state of the single synchroniser stage.
                always_comb begin
                    sync_a_d = i_0;
                    sync_b_d = i_1;
                end
            end else begin : g_multi
                // Shift every stage up by one position and load the raw inputs into stage 0.
                always_comb begin
                    sync_a_d = {sync_a_q[(SYNC_STAGES-1)*WIDTH-1:0], i_0};
                    sync_b_d = {sync_b_q[(SYNC_STAGES-1)*WIDTH-1:0], i_1};
                end
            end

            // The synchroniser flops clock on every cycle, whatever the state of i_en.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sync_a_q <= '0;
                    sync_b_q <= '0;
                end else begin
                    sync_a_q <= sync_a_d;
                    sync_b_q <= sync_b_d;
                end
            end

            assign op_a = sync_a_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
            assign op_b = sync_b_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
        end else begin : g_nosync
            assign op_a = i_0;
            assign op_b = i_1;
        end
    endgenerate

    // Next state of the result, valid and counter registers.
    // A toggle is detected by comparing the next result value with the current one.
    always_comb begin
        o0_d    = i_en ? ~(op_a & op_b) : o0_q;
        valid_d = valid_q | i_en;
        cnt_d   = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = '0;
        end else if ((o0_d != o0_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers. Reset loads the result of a NAND of two all-zero operands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o0_q    <= '1;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            o0_q    <= o0_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_0          = o0_q;
    assign o_valid      = valid_q;
    assign o_toggle_cnt = cnt_q;

endmodule

// File: tb/tb_nand_gate_core.sv
// Directed testbench for nand_gate_core. It uses three instances:
//   dut_a: WIDTH=1, SYNC_STAGES=0, CNT_W=16 (truth table, reset, enable)
//   dut_b: WIDTH=1, SYNC_STAGES=2, CNT_W=16 (latency through the synchroniser)
//   dut_c: WIDTH=4, SYNC_STAGES=0, CNT_W=2  (wide operands, counter saturation)
module tb_nand_gate_core;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_i0, a_i1, a_en, a_clr;
    logic       a_o0, a_comb, a_valid;
    logic [15:0] a_cnt;

    logic       b_i0, b_i1, b_en, b_clr;
    logic       b_o0, b_comb, b_valid;
    logic [15:0] b_cnt;

    logic [3:0] c_i0, c_i1;
    logic       c_en, c_clr;
    logic [3:0] c_o0, c_comb;
    logic       c_valid;
    logic [1:0] c_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nand_gate_core #(.WIDTH(1), .SYNC_STAGES(0), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_0(a_i0), .i_1(a_i1), .i_en(a_en),
        .i_clr_cnt(a_clr), .o_0(a_o0), .o_0_comb(a_comb), .o_valid(a_valid),
        .o_toggle_cnt(a_cnt)
    );

    nand_gate_core #(.WIDTH(1), .SYNC_STAGES(2), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_0(b_i0), .i_1(b_i1), .i_en(b_en),
        .i_clr_cnt(b_clr), .o_0(b_o0), .o_0_comb(b_comb), .o_valid(b_valid),
        .o_toggle_cnt(b_cnt)
    );

    nand_gate_core #(.WIDTH(4), .SYNC_STAGES(0), .CNT_W(2)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_0(c_i0), .i_1(c_i1), .i_en(c_en),
        .i_clr_cnt(c_clr), .o_0(c_o0), .o_0_comb(c_comb), .o_valid(c_valid),
        .o_toggle_cnt(c_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_i0 = 1'b0; a_i1 = 1'b0; a_en = 1'b1; a_clr = 1'b0;
        b_i0 = 1'b0; b_i1 = 1'b0; b_en = 1'b1; b_clr = 1'b0;
        c_i0 = 4'h0; c_i1 = 4'h0; c_en = 1'b0; c_clr = 1'b0;
        tick();
        n_cmp++; if (a_o0 !== 1'b1) begin n_bad++; $display("FAIL reset_a_o0: got %b want 1", a_o0); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_a_cnt: got %0d want 0", a_cnt); end
        n_cmp++; if (b_o0 !== 1'b1) begin n_bad++; $display("FAIL reset_b_o0: got %b want 1", b_o0); end
        n_cmp++; if (c_o0 !== 4'hF) begin n_bad++; $display("FAIL reset_c_o0: got %h want f", c_o0); end
        n_cmp++; if (c_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_c_cnt: got %0d want 0", c_cnt); end
        rst_n = 1'b1;
    endtask

    // Drive each input pair to dut_a for 250 ns (25 clocks).
    task automatic test_truth_table();
        logic [1:0] vec [4];
        logic       exp [4];
        vec[0] = 2'b00; exp[0] = 1'b1;
        vec[1] = 2'b01; exp[1] = 1'b1;
        vec[2] = 2'b10; exp[2] = 1'b1;
        vec[3] = 2'b11; exp[3] = 1'b0;
        a_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_i0 = vec[i][1];
            a_i1 = vec[i][0];
            #1;
            n_cmp++; if (a_comb !== exp[i]) begin n_bad++; $display("FAIL tt_comb[%0d]: got %b want %b", i, a_comb, exp[i]); end
            tick();
            n_cmp++; if (a_o0 !== exp[i]) begin n_bad++; $display("FAIL tt_o0[%0d]: got %b want %b", i, a_o0, exp[i]); end
            repeat (24) tick();
        end
        // Only the final 10->11 step changes o_0 (1->0).
        n_cmp++; if (a_cnt !== 16'd1) begin n_bad++; $display("FAIL tt_cnt: got %0d want 1", a_cnt); end
        n_cmp++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL tt_valid: got %b want 1", a_valid); end
    endtask

    // Assert reset between clock edges while the inputs are 11 and o_0 is 0.
    task automatic test_reset_midrun();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_o0 !== 1'b1) begin n_bad++; $display("FAIL mid_rst_o0: got %b want 1", a_o0); end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", a_cnt); end
        n_cmp++; if (a_comb !== 1'b0) begin n_bad++; $display("FAIL mid_rst_comb: got %b want 0", a_comb); end
        a_en = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_enable_hold();
        a_i0 = 1'b1; a_i1 = 1'b1; a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (a_o0 !== 1'b1) begin n_bad++; $display("FAIL hold_o0[%0d]: got %b want 1", i, a_o0); end
        end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL hold_valid: got %b want 0", a_valid); end
        a_en = 1'b1;
        tick();
        n_cmp++; if (a_o0 !== 1'b0) begin n_bad++; $display("FAIL en_o0: got %b want 0", a_o0); end
        n_cmp++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL en_valid: got %b want 1", a_valid); end
        n_cmp++; if (a_cnt !== 16'd1) begin n_bad++; $display("FAIL en_cnt: got %0d want 1", a_cnt); end
        // With i_en low, o_0 and o_valid must hold even though the inputs change.
        a_en = 1'b0; a_i0 = 1'b0; a_i1 = 1'b0;
        repeat (3) tick();
        n_cmp++; if (a_o0 !== 1'b0) begin n_bad++; $display("FAIL dis_o0: got %b want 0", a_o0); end
        n_cmp++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL dis_valid: got %b want 1", a_valid); end
        n_cmp++; if (a_cnt !== 16'd1) begin n_bad++; $display("FAIL dis_cnt: got %0d want 1", a_cnt); end
    endtask

    // With two synchroniser stages, o_0 must fall on the third edge after the step.
    task automatic test_latency();
        logic exp [3];
        exp[0] = 1'b1; exp[1] = 1'b1; exp[2] = 1'b0;
        b_en = 1'b1; b_i0 = 1'b0; b_i1 = 1'b0;
        repeat (4) tick();
        b_i0 = 1'b1; b_i1 = 1'b1;
        #1;
        n_cmp++; if (b_comb !== 1'b0) begin n_bad++; $display("FAIL lat_comb: got %b want 0", b_comb); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (b_o0 !== exp[i]) begin n_bad++; $display("FAIL lat_o0[edge %0d]: got %b want %b", i + 1, b_o0, exp[i]); end
        end
        n_cmp++; if (b_cnt !== 16'd1) begin n_bad++; $display("FAIL lat_cnt: got %0d want 1", b_cnt); end
    endtask

    task automatic test_wide();
        c_en = 1'b1;
        c_i0 = 4'b1100; c_i1 = 4'b1010;
        #1;
        n_cmp++; if (c_comb !== 4'b0111) begin n_bad++; $display("FAIL wide_comb: got %b want 0111", c_comb); end
        tick();
        n_cmp++; if (c_o0 !== 4'b0111) begin n_bad++; $display("FAIL wide_o0: got %b want 0111", c_o0); end
        n_cmp++; if (c_cnt !== 2'd1) begin n_bad++; $display("FAIL wide_cnt: got %0d want 1", c_cnt); end
        // Holding the same inputs leaves o_0 unchanged, so the count must not move.
        tick();
        n_cmp++; if (c_cnt !== 2'd1) begin n_bad++; $display("FAIL wide_nochg_cnt: got %0d want 1", c_cnt); end
    endtask

    // Toggle o_0 every cycle. A 2-bit counter saturates at 3, and a clear
    // overrides an increment on the same edge.
    task automatic test_counter();
        logic [1:0] exp [4];
        exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3;
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        n_cmp++; if (c_cnt !== 2'd0) begin n_bad++; $display("FAIL cnt_clr0: got %0d want 0", c_cnt); end
        for (int i = 0; i < 4; i++) begin
            c_i0 = (i % 2 == 0) ? 4'hF : 4'h0;
            c_i1 = c_i0;
            tick();
            n_cmp++; if (c_cnt !== exp[i]) begin n_bad++; $display("FAIL cnt_sat[%0d]: got %0d want %0d", i, c_cnt, exp[i]); end
        end
        // o_0 is 1111 at this point. Toggle it while clearing.
        c_i0 = 4'hF; c_i1 = 4'hF; c_clr = 1'b1;
        tick();
        n_cmp++; if (c_o0 !== 4'h0) begin n_bad++; $display("FAIL cnt_clr_o0: got %h want 0", c_o0); end
        n_cmp++; if (c_cnt !== 2'd0) begin n_bad++; $display("FAIL cnt_clr_prio: got %0d want 0", c_cnt); end
        c_clr = 1'b0; c_i0 = 4'h0; c_i1 = 4'h0;
        tick();
        n_cmp++; if (c_cnt !== 2'd1) begin n_bad++; $display("FAIL cnt_after_clr: got %0d want 1", c_cnt); end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_reset_midrun();
        test_enable_hold();
        test_latency();
        test_wide();
        test_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
